// File: rtl/stego_decode.sv
// Steganographic block decoder: scans a 64x64 image in 4x4 blocks, finds the two reference
// levels per block, rebuilds a base-3 word from the data pixels. Option: STEGO_DECODE_ERR_CHECK_EN.
module stego_decode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [5:0]  row,
  output logic [5:0]  col,
  input  logic [23:0] in_pix,
  output logic [15:0] word,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        busy,
  output logic        decode_done,
  output logic        err
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] P1_ADDR = 3'd1;
  localparam logic [2:0] P1_SAMP = 3'd2;
  localparam logic [2:0] P2_ADDR = 3'd3;
  localparam logic [2:0] P2_SAMP = 3'd4;
  localparam logic [2:0] EMIT    = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;

  logic [2:0]  state;
  logic [5:0]  base_r, base_c;
  logic [3:0]  idx, kb;
  logic [7:0]  ref_a, ref_b;
  logic        has_b;
  logic [23:0] acc, pw;

  logic [7:0]        v, ref_sel;
  logic signed [8:0] da, dr;
  logic              near_a, skip, last_blk;
  logic [1:0]        digit;
  logic [23:0]       term, acc_nxt, pw_nxt;
  logic [3:0]        nidx;
  logic [5:0]        nxt_r, nxt_c;
  logic              unused_pix;

  assign unused_pix = ^{in_pix[23:16], in_pix[7:0]};
  assign v = in_pix[15:8];

  // Differences are taken 9-bit signed so levels near 0/255 never wrap.
  assign da      = $signed({1'b0, v}) - $signed({1'b0, ref_a});
  assign near_a  = (da >= -9'sd1) && (da <= 9'sd1);
  assign ref_sel = near_a ? ref_a : ref_b;
  assign dr      = $signed({1'b0, v}) - $signed({1'b0, ref_sel});
  assign skip    = (idx == 4'd0) || (has_b ? (idx == kb) : (idx == 4'd1));

  always_comb begin
    digit = 2'd0;
    if (dr == 9'sd1)       digit = 2'd1;
    else if (dr == -9'sd1) digit = 2'd2;
  end

  always_comb begin
    term = 24'd0;
    if (digit == 2'd1)      term = pw;
    else if (digit == 2'd2) term = pw << 1;
  end

  assign acc_nxt  = skip ? acc : acc + term;
  assign pw_nxt   = skip ? pw : (pw << 1) + pw;
  assign nidx     = idx + 4'd1;
  assign nxt_c    = base_c + 6'd4;
  assign nxt_r    = (base_c == 6'd60) ? base_r + 6'd4 : base_r;
  assign last_blk = (base_r == 6'd60) && (base_c == 6'd60);

  assign word_valid  = (state == EMIT);
  assign busy        = (state != IDLE) && (state != DONE);
  assign decode_done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      base_r <= 6'd0;
      base_c <= 6'd0;
      row    <= 6'd0;
      col    <= 6'd0;
      idx    <= 4'd0;
      kb     <= 4'd0;
      ref_a  <= 8'd0;
      ref_b  <= 8'd0;
      has_b  <= 1'b0;
      acc    <= 24'd0;
      pw     <= 24'd1;
      word   <= 16'd0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          state  <= P1_ADDR;
          base_r <= 6'd0;
          base_c <= 6'd0;
          row    <= 6'd0;
          col    <= 6'd0;
          idx    <= 4'd0;
          has_b  <= 1'b0;
          acc    <= 24'd0;
          pw     <= 24'd1;
        end
        P1_ADDR: state <= P1_SAMP;
        P1_SAMP: begin
          // B defaults to A so a uniform block still has a defined second reference.
          if (idx == 4'd0) begin
            ref_a <= v;
            ref_b <= v;
          end else if (!has_b && !near_a) begin
            ref_b <= v;
            kb    <= idx;
            has_b <= 1'b1;
          end
          idx   <= nidx;
          row   <= base_r + {4'd0, nidx[3:2]};
          col   <= base_c + {4'd0, nidx[1:0]};
          state <= (idx == 4'd15) ? P2_ADDR : P1_ADDR;
        end
        P2_ADDR: state <= P2_SAMP;
        P2_SAMP: begin
          acc <= acc_nxt;
          pw  <= pw_nxt;
          idx <= nidx;
          row <= base_r + {4'd0, nidx[3:2]};
          col <= base_c + {4'd0, nidx[1:0]};
          if (idx == 4'd15) begin
            state <= EMIT;
            word  <= acc_nxt[15:0];
          end else begin
            state <= P2_ADDR;
          end
        end
        EMIT: if (word_ready) begin
          if (last_blk) begin
            state <= DONE;
          end else begin
            state  <= P1_ADDR;
            base_r <= nxt_r;
            base_c <= nxt_c;
            row    <= nxt_r;
            col    <= nxt_c;
            has_b  <= 1'b0;
            acc    <= 24'd0;
            pw     <= 24'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STEGO_DECODE_ERR_CHECK_EN
  logic bad;
  assign bad = (dr < -9'sd1) || (dr > 9'sd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                         err <= 1'b0;
    else if ((state == IDLE || state == DONE) && start) err <= 1'b0;
    else if (state == P2_SAMP && !skip && bad)          err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif
endmodule
